// File: rtl/al_pkg.sv
// Shared definitions for the alarm-clock key-entry path: FSM states,
// digit positions and the BCD limits of a 24-hour HH:MM value.
package al_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTRY = 2'd1,
    ST_LOAD  = 2'd2
  } al_state_e;

  // Index of the next digit expected, most significant first.
  localparam logic [1:0] POS_H1 = 2'd0;
  localparam logic [1:0] POS_H0 = 2'd1;
  localparam logic [1:0] POS_M1 = 2'd2;
  localparam logic [1:0] POS_M0 = 2'd3;

  // Largest legal value per digit; H0 is capped at 3 only in the 20s.
  localparam logic [3:0] H1_MAX     = 4'd2;
  localparam logic [3:0] H0_MAX_20S = 4'd3;
  localparam logic [3:0] M1_MAX     = 4'd5;
  localparam logic [3:0] DIGIT_MAX  = 4'd9;

endpackage

// File: rtl/al_digit_check.sv
// Combinational legality check for one BCD digit of a 24-hour HH:MM entry.
// Shared by the alarm-entry and clock-set paths.
module al_digit_check
  import al_pkg::*;
(
  input  logic [1:0] digit_pos,
  input  logic [3:0] key_code,
  input  logic [3:0] h1,
  output logic       legal
);

  // Non-digit codes are never legal; otherwise apply the per-position limit.
  always_comb begin
    legal = 1'b0;
    if (key_code <= DIGIT_MAX) begin
      case (digit_pos)
        POS_H1:  legal = (key_code <= H1_MAX);
        POS_H0:  legal = (h1 == H1_MAX) ? (key_code <= H0_MAX_20S) : 1'b1;
        POS_M1:  legal = (key_code <= M1_MAX);
        default: legal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/al_key_entry.sv
// Alarm-time entry: collects H1 H0 M1 M0 from the keypad, rejects digits
// outside 24-hour limits and strobes load_alarm when all four are in.
// Optional inactivity abort is built when AL_KEY_ENTRY_TIMEOUT_EN is defined.
module al_key_entry
  import al_pkg::*;
#(
  parameter int unsigned TIMEOUT_SECS = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_alarm,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        one_sec,
  output logic [15:0] new_alarm_time,
  output logic        load_alarm,
  output logic        entering,
  output logic [1:0]  digit_pos,
  output logic        key_error
);

  al_state_e   state_q, state_d;
  logic [15:0] buf_q, buf_d;
  logic [1:0]  pos_q, pos_d;
  logic        err_d, err_q;
  logic        load_q, entering_q;
  logic        legal;
  logic        digit_key;

  // Codes 10-15 are treated as if no key arrived at all.
  assign digit_key = key_valid && (key_code <= DIGIT_MAX);

  al_digit_check u_check (
    .digit_pos (pos_q),
    .key_code  (key_code),
    .h1        (buf_q[15:12]),
    .legal     (legal)
  );

`ifdef AL_KEY_ENTRY_TIMEOUT_EN
  localparam logic [7:0] TMO = TIMEOUT_SECS[7:0];
  logic [7:0] cnt_q, cnt_d;
`else
  // one_sec and TIMEOUT_SECS have no function without the abort path.
  logic unused_tmo;
  assign unused_tmo = one_sec | (TIMEOUT_SECS == 0);
`endif

  // Next-state, buffer, position, error and idle-counter decisions.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    pos_d   = pos_q;
    err_d   = 1'b0;
`ifdef AL_KEY_ENTRY_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (key_alarm) begin
          state_d = ST_ENTRY;
          buf_d   = 16'h0000;
          pos_d   = POS_H1;
`ifdef AL_KEY_ENTRY_TIMEOUT_EN
          cnt_d   = 8'd0;
`endif
        end
      end
      ST_ENTRY: begin
        if (key_alarm) begin
          // Restart wins over a simultaneous digit, which is dropped.
          buf_d = 16'h0000;
          pos_d = POS_H1;
`ifdef AL_KEY_ENTRY_TIMEOUT_EN
          cnt_d = 8'd0;
`endif
        end else if (digit_key) begin
          // Any digit, accepted or not, counts as activity.
`ifdef AL_KEY_ENTRY_TIMEOUT_EN
          cnt_d = 8'd0;
`endif
          if (legal) begin
            case (pos_q)
              POS_H1:  buf_d[15:12] = key_code;
              POS_H0:  buf_d[11:8]  = key_code;
              POS_M1:  buf_d[7:4]   = key_code;
              default: buf_d[3:0]   = key_code;
            endcase
            pos_d = pos_q + 2'd1;
            if (pos_q == POS_M0) state_d = ST_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
`ifdef AL_KEY_ENTRY_TIMEOUT_EN
        else if (one_sec) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q + 8'd1 == TMO) state_d = ST_IDLE;
        end
`endif
      end
      ST_LOAD: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; outputs are registered off next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      buf_q      <= 16'h0000;
      pos_q      <= POS_H1;
      err_q      <= 1'b0;
      load_q     <= 1'b0;
      entering_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      pos_q      <= pos_d;
      err_q      <= err_d;
      load_q     <= (state_d == ST_LOAD);
      entering_q <= (state_d == ST_ENTRY);
    end
  end

`ifdef AL_KEY_ENTRY_TIMEOUT_EN
  // Seconds elapsed since the last activity in the current entry.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= 8'd0;
    else       cnt_q <= cnt_d;
  end
`endif

  assign new_alarm_time = buf_q;
  assign load_alarm     = load_q;
  assign entering       = entering_q;
  assign digit_pos      = pos_q;
  assign key_error      = err_q;

endmodule

// File: tb/tb_al_key_entry.sv
// Bench for al_key_entry: directed test-plan scenarios plus random key
// traffic, every cycle compared against a digit-array reference model.
module tb_al_key_entry;

  localparam int TSECS = 10;

  logic        clk = 1'b0;
  logic        reset, key_alarm, key_valid, one_sec;
  logic [3:0]  key_code;
  logic [15:0] new_alarm_time;
  logic        load_alarm, entering, key_error;
  logic [1:0]  digit_pos;

  int checks = 0;
  int failures = 0;

  // Reference model: 0 = idle, 1 = entering, 2 = loading.
  int m_mode, m_pos, m_cnt, m_err;
  int m_d [4];

  al_key_entry #(.TIMEOUT_SECS(TSECS)) dut (
    .clk(clk), .reset(reset), .key_alarm(key_alarm), .key_valid(key_valid),
    .key_code(key_code), .one_sec(one_sec), .new_alarm_time(new_alarm_time),
    .load_alarm(load_alarm), .entering(entering), .digit_pos(digit_pos),
    .key_error(key_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int limit_for(input int pos);
    if (pos == 0) return 2;
    if (pos == 1) return (m_d[0] == 2) ? 3 : 9;
    if (pos == 2) return 5;
    return 9;
  endfunction

  function automatic int model_time();
    return m_d[0] * 4096 + m_d[1] * 256 + m_d[2] * 16 + m_d[3];
  endfunction

  task automatic model_step(input bit rst, input bit ka, input bit kv, input int kc, input bit os);
    m_err = 0;
    if (rst) begin
      m_mode = 0; m_pos = 0; m_cnt = 0;
      for (int i = 0; i < 4; i++) m_d[i] = 0;
    end else if (m_mode == 2) begin
      m_mode = 0;
    end else if (ka) begin
      m_mode = 1; m_pos = 0; m_cnt = 0;
      for (int i = 0; i < 4; i++) m_d[i] = 0;
    end else if (m_mode == 1) begin
      if (kv && kc <= 9) begin
        m_cnt = 0;
        if (kc <= limit_for(m_pos)) begin
          m_d[m_pos] = kc;
          if (m_pos == 3) m_mode = 2;
          m_pos = (m_pos + 1) % 4;
        end else begin
          m_err = 1;
        end
      end else if (os) begin
`ifdef AL_KEY_ENTRY_TIMEOUT_EN
        m_cnt++;
        if (m_cnt == TSECS) m_mode = 0;
`endif
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model, then compare after the edge.
  task automatic cyc(input bit rst, input bit ka, input bit kv, input int kc, input bit os);
    reset = rst; key_alarm = ka; key_valid = kv; key_code = kc[3:0]; one_sec = os;
    model_step(rst, ka, kv, kc, os);
    @(posedge clk);
    #1;
    chk("time", 32'(new_alarm_time), 32'(model_time()));
    chk("load", 32'(load_alarm), 32'(m_mode == 2));
    chk("entering", 32'(entering), 32'(m_mode == 1));
    chk("pos", 32'(digit_pos), 32'(m_pos));
    chk("error", 32'(key_error), 32'(m_err));
  endtask

  task automatic idle_cyc();
    cyc(0, 0, 0, 0, 0);
  endtask

  task automatic key(input int kc);
    cyc(0, 0, 1, kc, 0);
  endtask

  initial begin
    reset = 1; key_alarm = 0; key_valid = 0; key_code = 0; one_sec = 0;
    m_mode = 0; m_pos = 0; m_cnt = 0; m_err = 0;
    for (int i = 0; i < 4; i++) m_d[i] = 0;

    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 1, 5, 1);
    chk("rst_time", 32'(new_alarm_time), 32'h0);
    chk("rst_enter", 32'(entering), 32'h0);

    // 07:30, digits back to back.
    cyc(0, 1, 0, 0, 0);
    chk("enter_rise", 32'(entering), 32'h1);
    key(0); key(7); key(3); key(0);
    chk("load_0730", 32'(load_alarm), 32'h1);
    chk("time_0730", 32'(new_alarm_time), 32'h0730);
    idle_cyc();
    chk("load_once", 32'(load_alarm), 32'h0);
    chk("enter_low", 32'(entering), 32'h0);

    // 23:59 with a rejected 4 in H0.
    cyc(0, 1, 0, 0, 0);
    key(2); key(4);
    chk("err_h0", 32'(key_error), 32'h1);
    chk("pos_h0", 32'(digit_pos), 32'h1);
    key(3); key(5); key(9);
    chk("time_2359", 32'(new_alarm_time), 32'h2359);
    idle_cyc();

    // 16:45 with a rejected 7 in M1.
    cyc(0, 1, 0, 0, 0);
    key(1); key(6); key(7);
    chk("err_m1", 32'(key_error), 32'h1);
    key(4); key(5);
    chk("time_1645", 32'(new_alarm_time), 32'h1645);
    idle_cyc();

    // Partial entry then ten seconds of silence.
    cyc(0, 1, 0, 0, 0);
    key(1); key(2);
    for (int i = 0; i < TSECS; i++) begin
      cyc(0, 0, 0, 0, 1);
      idle_cyc();
    end
`ifdef AL_KEY_ENTRY_TIMEOUT_EN
    chk("timeout", 32'(entering), 32'h0);
`else
    chk("timeout", 32'(entering), 32'h1);
`endif
    chk("timeout_nold", 32'(load_alarm), 32'h0);

    // Restart with a simultaneous digit.
    cyc(0, 1, 0, 0, 0);
    key(1); key(2);
    cyc(0, 1, 1, 5, 0);
    chk("restart_time", 32'(new_alarm_time), 32'h0);
    chk("restart_pos", 32'(digit_pos), 32'h0);

    // Reset at position 2.
    key(1); key(2);
    cyc(1, 0, 0, 0, 0);
    chk("rst_mid_pos", 32'(digit_pos), 32'h0);
    chk("rst_mid_enter", 32'(entering), 32'h0);
    chk("rst_mid_time", 32'(new_alarm_time), 32'h0);

    // Random traffic: mostly digits, occasional restarts, ticks and resets.
    for (int n = 0; n < 4000; n++) begin
      bit r, ka, kv, os;
      int kc;
      r  = ($urandom_range(0, 199) == 0);
      ka = ($urandom_range(0, 29) == 0);
      kv = ($urandom_range(0, 2) != 0);
      os = ($urandom_range(0, 3) == 0);
      kc = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 5);
      cyc(r, ka, kv, kc, os);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
